gshare_branch_predictor: RTL and testbench

//   Parametrised direction predictor: table of 2^INDEX_BITS saturating counters, indexed by
//   PC word bits XOR global history (gshare). Fetch reads it combinationally; EX trains it.

---
 rtl/gshare_branch_predictor_if.sv | 40 ++++
 rtl/gshare_branch_predictor.sv | 160 ++++++++++++++++
 tb/tb_gshare_branch_predictor.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/gshare_branch_predictor_if.sv
// Fetch/EX-side signal bundle for gshare_branch_predictor.
// The Stat* counters exist only when BP_STATS_EN is defined.
interface gshare_branch_predictor_if #(
  parameter int PC_W      = 32,
  parameter int HIST_BITS = 5
);
  // HIST_BITS = 0 (plain bimodal) still carries a one-bit, always-zero history
  localparam int HW = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [PC_W-1:0] PredictPC;
  logic            Taken;
  logic [HW-1:0]   PredictHist;
  logic            Ready;
  logic            Branch_EX;
  logic [PC_W-1:0] UpdatePC;
  logic [HW-1:0]   UpdateHist;
  logic            UpdatePred;
  logic            Outcome;
  logic            Mispredict;
`ifdef BP_STATS_EN
  logic [31:0]     StatBranches;
  logic [31:0]     StatMispredicts;
`endif

  modport master (
    output PredictPC, Branch_EX, UpdatePC, UpdateHist, UpdatePred, Outcome,
`ifdef BP_STATS_EN
    input  StatBranches, StatMispredicts,
`endif
    input  Taken, PredictHist, Ready, Mispredict
  );

  modport slave (
    input  PredictPC, Branch_EX, UpdatePC, UpdateHist, UpdatePred, Outcome,
`ifdef BP_STATS_EN
    output StatBranches, StatMispredicts,
`endif
    output Taken, PredictHist, Ready, Mispredict
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// gshare direction predictor: saturating-counter table indexed by PC ^ global history,
// cleared by a post-reset sweep. Define BP_STATS_EN to add branch/mispredict counters.
module gshare_branch_predictor #(
  parameter int INDEX_BITS = 5,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 5,
  parameter int PC_W       = 32
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  gshare_branch_predictor_if.slave   bp
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam int HW    = (HIST_BITS > 0) ? HIST_BITS : 1;
  localparam logic [CTR_BITS-1:0]   CTR_WNT  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0]   CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0]   CTR_ZERO = {CTR_BITS{1'b0}};
  localparam logic [CTR_BITS-1:0]   CTR_ONE  = CTR_BITS'(1);
  localparam logic [INDEX_BITS-1:0] PTR_LAST = {INDEX_BITS{1'b1}};
  localparam logic [INDEX_BITS-1:0] PTR_ONE  = INDEX_BITS'(1);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                  state_q, state_d;
  logic [INDEX_BITS-1:0]   ptr_q, ptr_d;
  logic [HW-1:0]           ghr_q, ghr_d;
  logic                    mispredict_q, mispredict_d;
  logic [CTR_BITS-1:0]     table_q [DEPTH];
  logic                    tbl_we_d;
  logic [INDEX_BITS-1:0]   tbl_idx_d;
  logic [CTR_BITS-1:0]     tbl_wdata_d;
  logic [INDEX_BITS-1:0]   idx_pred_s, idx_upd_s;
  logic                    upd_fire_s;

  function automatic logic [INDEX_BITS-1:0] calc_idx(input logic [PC_W-1:0] pc,
                                                     input logic [HW-1:0]   hist);
    logic [INDEX_BITS-1:0] h;
    h = {INDEX_BITS{1'b0}};
    for (int i = 0; i < HIST_BITS; i++) h[i] = hist[i];
    return pc[INDEX_BITS+1:2] ^ h;
  endfunction

  function automatic logic [CTR_BITS-1:0] sat_ctr(input logic [CTR_BITS-1:0] ctr,
                                                  input logic                up);
    logic [CTR_BITS-1:0] r;
    if (up) r = (ctr == CTR_MAX)  ? ctr : ctr + CTR_ONE;
    else    r = (ctr == CTR_ZERO) ? ctr : ctr - CTR_ONE;
    return r;
  endfunction

  assign idx_pred_s = calc_idx(bp.PredictPC, ghr_q);
  assign idx_upd_s  = calc_idx(bp.UpdatePC, bp.UpdateHist);
  assign upd_fire_s = (state_q == ST_RUN) && bp.Branch_EX;

  // State register: FSM, sweep pointer, history and mispredict flag
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= ST_INIT;
      ptr_q        <= {INDEX_BITS{1'b0}};
      ghr_q        <= {HW{1'b0}};
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ghr_q        <= ghr_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Counter table is RAM-like: contents come from the sweep, not from reset
  always_ff @(posedge Clk) begin
    if (tbl_we_d) table_q[tbl_idx_d] <= tbl_wdata_d;
  end

  // Next-state: sweep writes WNT everywhere, RUN trains one counter per resolved branch
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    ghr_d        = ghr_q;
    mispredict_d = 1'b0;
    tbl_we_d     = 1'b0;
    tbl_idx_d    = ptr_q;
    tbl_wdata_d  = CTR_WNT;
    case (state_q)
      ST_INIT: begin
        tbl_we_d = 1'b1;
        ptr_d    = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) state_d = ST_RUN;
        else                   state_d = ST_INIT;
      end
      ST_RUN: begin
        if (bp.Branch_EX) begin
          tbl_we_d     = 1'b1;
          tbl_idx_d    = idx_upd_s;
          tbl_wdata_d  = sat_ctr(table_q[idx_upd_s], bp.Outcome);
          mispredict_d = (bp.UpdatePred != bp.Outcome);
          for (int i = 1; i < HIST_BITS; i++) ghr_d[i] = ghr_q[i-1];
          if (HIST_BITS > 0) ghr_d[0] = bp.Outcome;
          else               ghr_d[0] = 1'b0;
        end else begin
          tbl_we_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Outputs: prediction reads the pre-update table (no same-cycle bypass)
  always_comb begin
    bp.Taken       = 1'b0;
    bp.PredictHist = {HW{1'b0}};
    bp.Ready       = 1'b0;
    if (state_q == ST_RUN) begin
      bp.Taken       = table_q[idx_pred_s][CTR_BITS-1];
      bp.PredictHist = ghr_q;
      bp.Ready       = 1'b1;
    end else begin
      bp.Taken       = 1'b0;
    end
  end

  assign bp.Mispredict = mispredict_q;

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  // Saturating statistics, counted only for RUN-state updates
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (upd_fire_s) begin
      if (stat_br_q != 32'hFFFF_FFFF) stat_br_d = stat_br_q + 32'd1;
      if (mispredict_d && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_d = stat_mp_q + 32'd1;
    end else begin
      stat_br_d = stat_br_q;
    end
  end

  // Statistics registers
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stat_br_q <= 32'd0;
      stat_mp_q <= 32'd0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bp.StatBranches    = stat_br_q;
  assign bp.StatMispredicts = stat_mp_q;
`endif

  logic unused_s;
  assign unused_s = ^{bp.PredictPC[PC_W-1:INDEX_BITS+2], bp.PredictPC[1:0],
                      bp.UpdatePC[PC_W-1:INDEX_BITS+2], bp.UpdatePC[1:0],
                      bp.UpdateHist, upd_fire_s};

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed scoreboard bench: a gshare instance (HIST_BITS=5) and a bimodal one (HIST_BITS=0).
module tb_gshare_branch_predictor;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  gshare_branch_predictor_if #(.PC_W(32), .HIST_BITS(5)) bp_g ();
  gshare_branch_predictor_if #(.PC_W(32), .HIST_BITS(0)) bp_b ();

  gshare_branch_predictor #(.INDEX_BITS(5), .CTR_BITS(2), .HIST_BITS(5), .PC_W(32)) u_dut_g (
    .Clk(clk), .Rst_n(rst_n), .bp(bp_g)
  );
  gshare_branch_predictor #(.INDEX_BITS(5), .CTR_BITS(2), .HIST_BITS(0), .PC_W(32)) u_dut_b (
    .Clk(clk), .Rst_n(rst_n), .bp(bp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t        sb_q[$];
  logic [4:0]  ghr_m;
  int          br_m;
  int          mp_m;

  localparam int S_G_TAKEN = 0, S_G_HIST = 1, S_G_READY = 2, S_G_MISP = 3;
  localparam int S_B_TAKEN = 4, S_B_READY = 5, S_B_MISP = 6, S_G_SBR = 7, S_G_SMP = 8;

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      S_G_TAKEN: return {31'd0, bp_g.Taken};
      S_G_HIST:  return {27'd0, bp_g.PredictHist};
      S_G_READY: return {31'd0, bp_g.Ready};
      S_G_MISP:  return {31'd0, bp_g.Mispredict};
      S_B_TAKEN: return {31'd0, bp_b.Taken};
      S_B_READY: return {31'd0, bp_b.Ready};
      S_B_MISP:  return {31'd0, bp_b.Mispredict};
`ifdef BP_STATS_EN
      S_G_SBR:   return bp_g.StatBranches;
      S_G_SMP:   return bp_g.StatMispredicts;
`endif
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  // Compare every queued expectation at the negedge, then advance past the next posedge
  task automatic step();
    exp_t        e;
    logic [31:0] obs;
    @(negedge clk);
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pc_for(input logic [4:0] idx);
    return {25'd0, idx ^ ghr_m, 2'b00};
  endfunction

  // One resolved branch on the gshare instance; its results are checked at the next step
  task automatic upd_g(input logic [31:0] pc, input logic [4:0] hist,
                       input logic outcome, input logic pred, input string tag);
    bp_g.UpdatePC   = pc;
    bp_g.UpdateHist = hist;
    bp_g.Outcome    = outcome;
    bp_g.UpdatePred = pred;
    bp_g.Branch_EX  = 1'b1;
    step();
    bp_g.Branch_EX  = 1'b0;
    ghr_m = {ghr_m[3:0], outcome};
    br_m++;
    if (pred != outcome) mp_m++;
    push({tag, "_misp"}, S_G_MISP, {31'd0, pred ^ outcome});
    push({tag, "_hist"}, S_G_HIST, {27'd0, ghr_m});
  endtask

  task automatic upd_b(input logic outcome, input logic pred, input logic exp_taken,
                       input string tag);
    bp_b.Outcome    = outcome;
    bp_b.UpdatePred = pred;
    bp_b.Branch_EX  = 1'b1;
    step();
    bp_b.Branch_EX  = 1'b0;
    push({tag, "_misp"}, S_B_MISP, {31'd0, pred ^ outcome});
    push({tag, "_taken"}, S_B_TAKEN, {31'd0, exp_taken});
    step();
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!$isunknown(bp_g.Branch_EX) && !$isunknown(bp_b.Branch_EX)) else begin
        errors++;
        $error("FAIL branch_ex_x: observed=%b/%b expected=known", bp_g.Branch_EX, bp_b.Branch_EX);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] pat;
    pat   = 5'b00101;
    ghr_m = 5'd0;
    br_m  = 0;
    mp_m  = 0;
    rst_n = 1'b0;
    bp_g.PredictPC = 32'd0; bp_g.Branch_EX = 1'b0; bp_g.UpdatePC = 32'd0;
    bp_g.UpdateHist = 5'd0; bp_g.UpdatePred = 1'b0; bp_g.Outcome = 1'b0;
    bp_b.PredictPC = 32'h10; bp_b.Branch_EX = 1'b0; bp_b.UpdatePC = 32'h10;
    bp_b.UpdateHist = 1'b0; bp_b.UpdatePred = 1'b0; bp_b.Outcome = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    push("rst_ready", S_G_READY, 32'd0);
    push("rst_misp", S_G_MISP, 32'd0);
    push("rst_taken", S_G_TAKEN, 32'd0);
    push("rst_hist", S_G_HIST, 32'd0);
    push("rst_b_ready", S_B_READY, 32'd0);
    step();

    // Test 1: sweep takes exactly 32 cycles; branches during the sweep are ignored
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bp_g.Branch_EX = 1'b1; bp_g.Outcome = 1'b1; bp_g.UpdatePred = 1'b0; bp_g.UpdatePC = 32'h10;
      bp_b.Branch_EX = 1'b1; bp_b.Outcome = 1'b1; bp_b.UpdatePred = 1'b0;
      push("sweep_ready", S_G_READY, 32'd0);
      push("sweep_b_ready", S_B_READY, 32'd0);
      push("sweep_misp", S_G_MISP, 32'd0);
      push("sweep_taken", S_G_TAKEN, 32'd0);
      step();
    end
    bp_g.Branch_EX = 1'b0;
    bp_b.Branch_EX = 1'b0;
    push("run_ready", S_G_READY, 32'd1);
    push("run_b_ready", S_B_READY, 32'd1);
    push("run_misp", S_G_MISP, 32'd0);
    push("run_hist", S_G_HIST, 32'd0);
    push("run_b_taken", S_B_TAKEN, 32'd0);
    step();
    foreach (pat[k]) begin
      bp_g.PredictPC = {25'd0, 5'(k * 7), 2'b00};
      push("init_taken", S_G_TAKEN, 32'd0);
      step();
    end

    // Test 2: bimodal counter walk at PC 0x10 including both rails
    upd_b(1'b1, 1'b0, 1'b1, "bi_t1");
    upd_b(1'b1, 1'b1, 1'b1, "bi_t2");
    upd_b(1'b0, 1'b1, 1'b1, "bi_n1");
    upd_b(1'b0, 1'b1, 1'b0, "bi_n2");
    upd_b(1'b0, 1'b0, 1'b0, "bi_n3");
    upd_b(1'b0, 1'b0, 1'b0, "bi_floor");
    upd_b(1'b1, 1'b0, 1'b0, "bi_up1");
    upd_b(1'b1, 1'b0, 1'b1, "bi_up2");

    // Test 3: saturation at idx 20
    for (int k = 0; k < 5; k++) begin
      upd_g(32'h50, 5'd0, 1'b1, (k >= 2), "sat_t");
      bp_g.PredictPC = pc_for(5'd20);
      push("sat_taken", S_G_TAKEN, 32'd1);
      step();
    end
    upd_g(32'h50, 5'd0, 1'b0, 1'b1, "sat_n");
    bp_g.PredictPC = pc_for(5'd20);
    push("sat_after_nt", S_G_TAKEN, 32'd1);
    step();

    // Test 4: gshare aliasing with GHR = 00101 and PC 0x14 -> idx 0
    for (int k = 4; k >= 0; k--) begin
      upd_g(32'h7C, 5'd0, pat[k], 1'b0, "ghr_set");
      step();
    end
    bp_g.PredictPC = 32'h14;
    push("alias_hist", S_G_HIST, 32'd5);
    push("alias_pre", S_G_TAKEN, 32'd0);
    step();
    upd_g(32'h14, 5'b00101, 1'b1, 1'b0, "alias_train");
    bp_g.PredictPC = 32'h14;
    push("alias_other_ghr", S_G_TAKEN, 32'd0);
    step();
    for (int k = 4; k >= 0; k--) begin
      upd_g(32'h7C, 5'd0, pat[k], 1'b1, "ghr_reset");
      step();
    end
    bp_g.PredictPC = 32'h14;
    push("alias_hit", S_G_TAKEN, 32'd1);
    step();
    bp_g.PredictPC = 32'h00;
    push("alias_other_pc", S_G_TAKEN, 32'd0);
    step();

    // Test 5: same-cycle predict/update to idx 3 (counter 01, Outcome taken)
    bp_g.PredictPC = pc_for(5'd3);
    push("same_pre", S_G_TAKEN, 32'd0);
    upd_g(32'h0C, 5'd0, 1'b1, 1'b0, "same_upd");
    bp_g.PredictPC = pc_for(5'd3);
    push("same_post", S_G_TAKEN, 32'd1);
    step();
    push("misp_one_cycle", S_G_MISP, 32'd0);
`ifdef BP_STATS_EN
    push("stat_br", S_G_SBR, br_m);
    push("stat_mp", S_G_SMP, mp_m);
`endif
    step();

    // Test 6: reset pulsed at sweep cycle 10 restarts the full 32-cycle sweep
    rst_n = 1'b0;
    ghr_m = 5'd0;
    push("rst2_ready", S_G_READY, 32'd0);
    push("rst2_hist", S_G_HIST, 32'd0);
    step();
    rst_n = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    push("rst3_ready", S_G_READY, 32'd0);
    push("rst3_misp", S_G_MISP, 32'd0);
`ifdef BP_STATS_EN
    push("rst3_stat_br", S_G_SBR, 32'd0);
    push("rst3_stat_mp", S_G_SMP, 32'd0);
`endif
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      push("resweep_ready", S_G_READY, 32'd0);
      push("resweep_b_ready", S_B_READY, 32'd0);
      step();
    end
    bp_g.PredictPC = pc_for(5'd20);
    push("resweep_done", S_G_READY, 32'd1);
    push("resweep_idx20", S_G_TAKEN, 32'd0);
    push("resweep_b_taken", S_B_TAKEN, 32'd0);
    push("resweep_hist", S_G_HIST, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
